// File: rtl/ddr3_cmd_fsm_if.sv
// Request and command handshake bundle for the DDR3 command sequencer.
// master: request front end / DFI converter side; slave: the sequencer.
interface ddr3_cmd_fsm_if #(
    parameter int unsigned DDR_BANK_BITS = 3,
    parameter int unsigned DDR_ROW_BITS  = 15,
    parameter int unsigned DDR_COL_BITS  = 9
);
    localparam int unsigned ADDR_BITS = DDR_ROW_BITS + DDR_BANK_BITS + DDR_COL_BITS;

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_write_i;
    logic [ADDR_BITS-1:0]     req_addr_i;
    logic                     ctl_req_o;
    logic                     ctl_accept_i;
    logic [3:0]               ctl_cmd_o;
    logic [DDR_BANK_BITS-1:0] ctl_bank_o;
    logic [DDR_ROW_BITS-1:0]  ctl_addr_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, ctl_accept_i,
        input  req_ready_o, ctl_req_o, ctl_cmd_o, ctl_bank_o, ctl_addr_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, ctl_accept_i,
        output req_ready_o, ctl_req_o, ctl_cmd_o, ctl_bank_o, ctl_addr_o
    );
endinterface

// File: rtl/ddr3_cmd_fsm.sv
// Closed-page DDR3 command sequencer: ACT then RD/WR with auto-precharge,
// with periodic REF taking priority over new requests.
module ddr3_cmd_fsm #(
    parameter int unsigned DDR_BANK_BITS = 3,
    parameter int unsigned DDR_ROW_BITS  = 15,
    parameter int unsigned DDR_COL_BITS  = 9,
    parameter int unsigned T_RCD         = 2,
    parameter int unsigned T_RD_RECOV    = 4,
    parameter int unsigned T_WR_RECOV    = 12,
    parameter int unsigned T_RFC         = 16,
    parameter int unsigned T_REFI        = 780
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_done_i,
    ddr3_cmd_fsm_if.slave     bus,
    output logic              busy_o
);
    localparam int unsigned ADDR_BITS  = DDR_ROW_BITS + DDR_BANK_BITS + DDR_COL_BITS;
    localparam int unsigned T_MAX_A    = (T_RCD > T_RD_RECOV) ? T_RCD : T_RD_RECOV;
    localparam int unsigned T_MAX_B    = (T_WR_RECOV > T_RFC) ? T_WR_RECOV : T_RFC;
    localparam int unsigned T_MAX      = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned TIMER_BITS = $clog2(T_MAX + 1);
    localparam int unsigned REFI_BITS  = $clog2(T_REFI + 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_REF = 4'b0001;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ACT, S_RCD, S_RW, S_RECOV, S_REF, S_RFC
    } state_t;

    state_t                   r_state;
    logic [TIMER_BITS-1:0]    r_timer;
    logic [REFI_BITS-1:0]     r_ref_cnt;
    logic                     r_ref_pending;
    logic                     r_write;
    logic [DDR_BANK_BITS-1:0] r_bank;
    logic [DDR_COL_BITS-1:0]  r_col;
    logic                     r_ctl_req;
    logic [3:0]               r_ctl_cmd;
    logic [DDR_BANK_BITS-1:0] r_ctl_bank;
    logic [DDR_ROW_BITS-1:0]  r_ctl_addr;

    logic [DDR_ROW_BITS-1:0]  w_row;
    logic [DDR_BANK_BITS-1:0] w_bank;
    logic [DDR_COL_BITS-1:0]  w_col;
    logic [DDR_ROW_BITS-1:0]  w_rw_addr;
    logic                     w_ref_wrap;

    assign w_row  = bus.req_addr_i[ADDR_BITS-1 -: DDR_ROW_BITS];
    assign w_bank = bus.req_addr_i[DDR_COL_BITS +: DDR_BANK_BITS];
    assign w_col  = bus.req_addr_i[DDR_COL_BITS-1:0];

    assign w_ref_wrap = (r_ref_cnt == REFI_BITS'(T_REFI - 1));

    assign bus.req_ready_o = (r_state == S_IDLE) && !r_ref_pending;
    assign bus.ctl_req_o   = r_ctl_req;
    assign bus.ctl_cmd_o   = r_ctl_cmd;
    assign bus.ctl_bank_o  = r_ctl_bank;
    assign bus.ctl_addr_o  = r_ctl_addr;
    assign busy_o          = (r_state != S_IDLE);

    // Column address for RD/WR: zero-extended column with A10 set for auto-precharge.
    always_comb begin
        w_rw_addr                   = '0;
        w_rw_addr[DDR_COL_BITS-1:0] = r_col;
        w_rw_addr[10]               = 1'b1;
    end

    // Refresh interval counter; ref_pending saturates and is cleared by an accepted REF.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b0;
        end else if (r_state != S_INIT) begin
            r_ref_cnt     <= w_ref_wrap ? '0 : r_ref_cnt + REFI_BITS'(1);
            r_ref_pending <= (r_ref_pending && !(r_state == S_REF && bus.ctl_accept_i))
                             || w_ref_wrap;
        end
    end

    // Command sequencer with registered command outputs.
    // The timer holds T-1 in the first wait cycle and the state exits when it
    // reaches 1, so the next registered command lands exactly T cycles after
    // the accept. RFC exits one cycle earlier so a command issued from IDLE
    // still lands exactly T_RFC cycles after the REF accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_timer    <= '0;
            r_write    <= 1'b0;
            r_bank     <= '0;
            r_col      <= '0;
            r_ctl_req  <= 1'b0;
            r_ctl_cmd  <= CMD_NOP;
            r_ctl_bank <= '0;
            r_ctl_addr <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (init_done_i) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (r_ref_pending) begin
                        r_state    <= S_REF;
                        r_ctl_req  <= 1'b1;
                        r_ctl_cmd  <= CMD_REF;
                        r_ctl_bank <= '0;
                        r_ctl_addr <= '0;
                    end else if (bus.req_valid_i) begin
                        r_state    <= S_ACT;
                        r_write    <= bus.req_write_i;
                        r_bank     <= w_bank;
                        r_col      <= w_col;
                        r_ctl_req  <= 1'b1;
                        r_ctl_cmd  <= CMD_ACT;
                        r_ctl_bank <= w_bank;
                        r_ctl_addr <= w_row;
                    end
                end
                S_ACT: begin
                    if (bus.ctl_accept_i) begin
                        r_state   <= S_RCD;
                        r_timer   <= TIMER_BITS'(T_RCD - 1);
                        r_ctl_req <= 1'b0;
                        r_ctl_cmd <= CMD_NOP;
                    end
                end
                S_RCD: begin
                    if (r_timer <= TIMER_BITS'(1)) begin
                        r_state    <= S_RW;
                        r_ctl_req  <= 1'b1;
                        r_ctl_cmd  <= r_write ? CMD_WR : CMD_RD;
                        r_ctl_bank <= r_bank;
                        r_ctl_addr <= w_rw_addr;
                    end else begin
                        r_timer <= r_timer - TIMER_BITS'(1);
                    end
                end
                S_RW: begin
                    if (bus.ctl_accept_i) begin
                        r_state   <= S_RECOV;
                        r_timer   <= r_write ? TIMER_BITS'(T_WR_RECOV - 1)
                                             : TIMER_BITS'(T_RD_RECOV - 1);
                        r_ctl_req <= 1'b0;
                        r_ctl_cmd <= CMD_NOP;
                    end
                end
                S_RECOV: begin
                    if (r_timer <= TIMER_BITS'(1)) r_state <= S_IDLE;
                    else                           r_timer <= r_timer - TIMER_BITS'(1);
                end
                S_REF: begin
                    if (bus.ctl_accept_i) begin
                        r_state   <= S_RFC;
                        r_timer   <= TIMER_BITS'(T_RFC - 1);
                        r_ctl_req <= 1'b0;
                        r_ctl_cmd <= CMD_NOP;
                    end
                end
                S_RFC: begin
                    if (r_timer <= TIMER_BITS'(2)) r_state <= S_IDLE;
                    else                           r_timer <= r_timer - TIMER_BITS'(1);
                end
                default: r_state <= S_INIT;
            endcase
        end
    end
endmodule
